ip_tile_uc_dbg: RTL and testbench

Second-generation host tile for the 8-bit microcontroller. It replaces direct host clocking of the core with a run/step/halt engine that drives a core clock enable, and it buffers flash words to the core through a one-entry handshake with overrun detection. It also provides a parametric GPIO out-port count, a core-cycle counter and an optional PC breakpoint. It sits between the host register file (csr_in/csr_out, data_reg_a/b/c) and the uC_8bits core, all on one clock domain.

---
 rtl/ip_tile_uc_pkg.sv | 33 +++
 rtl/ip_tile_uc_run_fsm.sv | 97 +++++++++
 rtl/ip_tile_uc_dbg.sv | 166 ++++++++++++++++
 tb/tb_ip_tile_uc_dbg.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tile_uc_pkg.sv
// Shared encodings for the uC host tile: run-engine states and the host CSR bit map.
package ip_tile_uc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_t;

    localparam int CSR_RUN         = 0;
    localparam int CSR_STEP        = 1;
    localparam int CSR_HALT        = 2;
    localparam int CSR_CORE_RST    = 3;
    localparam int CSR_FLASH_VALID = 4;
    localparam int CSR_BP_EN       = 5;
    localparam int CSR_VIEW        = 7;
    localparam int STEP_CNT_LSB    = 8;
    localparam int STEP_CNT_W      = 8;

    localparam int STAT_CORE_CE    = 2;
    localparam int STAT_FLASH_FULL = 3;
    localparam int STAT_OVERRUN    = 4;
    localparam int STAT_BP_HIT     = 5;
    localparam int STAT_BOOT       = 6;
    localparam int STAT_SRAM_WE    = 7;

    // A zero step request still advances the core by one instruction.
    function automatic logic [STEP_CNT_W-1:0] step_load(input logic [STEP_CNT_W-1:0] n);
        return (n == '0) ? STEP_CNT_W'(1) : n;
    endfunction

endpackage

// File: rtl/ip_tile_uc_run_fsm.sv
// Run/step/halt engine for the uC core: state register, step down-counter,
// STEP edge detector and the combinational core clock enable.
//   state    | meaning
//   ST_IDLE  | core frozen, waiting for RUN or a STEP edge
//   ST_RUN   | free running until RUN drops or the breakpoint PC is reached
//   ST_STEP  | core enabled for exactly r_step_cnt cycles, breakpoints ignored
//   ST_BREAK | parked at the breakpoint PC; STEP edge or RUN low leaves
module ip_tile_uc_run_fsm
    import ip_tile_uc_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic                  i_halt,
    input  logic                  i_core_rst,
    input  logic [STEP_CNT_W-1:0] i_step_count,
    input  logic                  i_bp_match,
    output run_state_t            o_state,
    output logic                  o_core_ce,
    output logic                  o_bp_set
);

    run_state_t            r_state;
    run_state_t            w_state_nxt;
    logic [STEP_CNT_W-1:0] r_step_cnt;
    logic [STEP_CNT_W-1:0] w_step_cnt_nxt;
    logic                  r_step_prev;
    logic                  w_step_rise;

    assign w_step_rise = i_step & ~r_step_prev;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_step_cnt  <= '0;
            r_step_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_step_prev <= i_step;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_cnt_nxt = r_step_cnt;
        o_bp_set       = 1'b0;
        if (i_halt || i_core_rst) begin
            w_state_nxt = ST_IDLE;
            if (i_core_rst) begin
                w_step_cnt_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_step_rise) begin
                        w_state_nxt    = ST_STEP;
                        w_step_cnt_nxt = step_load(i_step_count);
                    end
                end
                ST_RUN: begin
                    if (!i_run) begin
                        w_state_nxt = ST_IDLE;
                    end else if (i_bp_match) begin
                        w_state_nxt = ST_BREAK;
                        o_bp_set    = 1'b1;
                    end
                end
                ST_STEP: begin
                    // Terminal count at 1: this is the last enabled cycle.
                    if (r_step_cnt <= STEP_CNT_W'(1)) begin
                        w_state_nxt    = i_run ? ST_RUN : ST_IDLE;
                        w_step_cnt_nxt = '0;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt - STEP_CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (w_step_rise) begin
                        w_state_nxt    = ST_STEP;
                        w_step_cnt_nxt = step_load(i_step_count);
                    end else if (!i_run) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_core_ce = ((r_state == ST_RUN) && !i_bp_match) || (r_state == ST_STEP);

endmodule

// File: rtl/ip_tile_uc_dbg.sv
// Host tile for the 8-bit uC: run/step/halt engine, one-entry flash buffer, GPIO and cycle counter.
// Define IP_TILE_UC_BREAKPOINT_EN to build the PC breakpoint compare and sticky bp_hit flag.
module ip_tile_uc_dbg
    import ip_tile_uc_pkg::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int GPIO_PORTS    = 2,
    parameter int PC_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [CSR_IN_WIDTH-1:0]   csr_in,
    input  logic [REG_WIDTH-1:0]      data_reg_a,
    input  logic [REG_WIDTH-1:0]      data_reg_b,
    input  logic [7:0]                in_gpio,
    input  logic [PC_WIDTH-1:0]       core_pc,
    input  logic [7:0]                core_sram_addr,
    input  logic [7:0]                core_sram_data_out,
    input  logic                      core_sram_we,
    input  logic                      core_bootstrapping,
    input  logic                      core_flash_ack,
    input  logic [8*GPIO_PORTS-1:0]   core_out,
    output logic                      core_ce,
    output logic                      core_rst_n,
    output logic [15:0]               core_flash_data,
    output logic                      core_flash_ready,
    output logic [7:0]                core_sram_data_in,
    output logic [7:0]                core_in,
    output logic [8*GPIO_PORTS-1:0]   out_gpio,
    output logic [REG_WIDTH-1:0]      data_reg_c,
    output logic [CSR_OUT_WIDTH-1:0]  csr_out,
    output logic                      csr_in_re,
    output logic                      csr_out_we
);

    run_state_t              w_state;
    logic                    w_core_ce;
    logic                    w_bp_match;
    logic                    w_bp_set;
    logic                    w_bp_hit;
    logic                    w_core_rst;
    logic                    w_fv_rise;
    logic                    w_ack;
    logic                    r_fv_prev;
    logic                    r_flash_full;
    logic                    r_overrun;
    logic [15:0]             r_flash_data;
    logic                    r_core_rst_n;
    logic [REG_WIDTH-1:0]    r_cycle_cnt;
    logic [8*GPIO_PORTS-1:0] r_out_gpio;
    logic                    w_unused_bits;

    assign w_core_rst = csr_in[CSR_CORE_RST];
    assign w_fv_rise  = csr_in[CSR_FLASH_VALID] & ~r_fv_prev;
    assign w_ack      = core_flash_ack & w_core_ce;

`ifdef IP_TILE_UC_BREAKPOINT_EN
    logic r_bp_hit;

    assign w_bp_match = csr_in[CSR_BP_EN] && (core_pc == data_reg_a[PC_WIDTH+15:16]);

    always_ff @(posedge clk) begin
        if (!arst_n || w_core_rst) begin
            r_bp_hit <= 1'b0;
        end else if (w_bp_set) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign w_bp_hit = r_bp_hit;
`else
    assign w_bp_match = 1'b0;
    assign w_bp_hit   = 1'b0;
`endif

    ip_tile_uc_run_fsm u_run_fsm (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_run        (csr_in[CSR_RUN]),
        .i_step       (csr_in[CSR_STEP]),
        .i_halt       (csr_in[CSR_HALT]),
        .i_core_rst   (w_core_rst),
        .i_step_count (csr_in[STEP_CNT_LSB +: STEP_CNT_W]),
        .i_bp_match   (w_bp_match),
        .o_state      (w_state),
        .o_core_ce    (w_core_ce),
        .o_bp_set     (w_bp_set)
    );

    // A new word arriving in the same cycle the core drains the buffer is not an overrun.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_fv_prev    <= 1'b0;
            r_flash_full <= 1'b0;
            r_overrun    <= 1'b0;
            r_flash_data <= '0;
        end else begin
            r_fv_prev <= csr_in[CSR_FLASH_VALID];
            if (w_core_rst) begin
                r_flash_full <= 1'b0;
                r_overrun    <= 1'b0;
            end else if (w_fv_rise) begin
                if (r_flash_full && !w_ack) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_flash_data <= data_reg_b[15:0];
                    r_flash_full <= 1'b1;
                end
            end else if (w_ack) begin
                r_flash_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_core_rst_n <= 1'b0;
            r_cycle_cnt  <= '0;
            r_out_gpio   <= '0;
        end else begin
            r_core_rst_n <= ~w_core_rst;
            r_out_gpio   <= core_out;
            if (w_core_rst) begin
                r_cycle_cnt <= '0;
            end else if (w_core_ce) begin
                r_cycle_cnt <= r_cycle_cnt + REG_WIDTH'(1);
            end
        end
    end

    always_comb begin
        data_reg_c = '0;
        if (csr_in[CSR_VIEW]) begin
            data_reg_c = r_cycle_cnt;
        end else begin
            data_reg_c[PC_WIDTH+15:0] = {core_pc, core_sram_data_out, core_sram_addr};
        end
    end

    always_comb begin
        csr_out                  = '0;
        csr_out[1:0]             = w_state;
        csr_out[STAT_CORE_CE]    = w_core_ce;
        csr_out[STAT_FLASH_FULL] = r_flash_full;
        csr_out[STAT_OVERRUN]    = r_overrun;
        csr_out[STAT_BP_HIT]     = w_bp_hit;
        csr_out[STAT_BOOT]       = core_bootstrapping;
        csr_out[STAT_SRAM_WE]    = core_sram_we;
    end

    assign core_ce           = w_core_ce;
    assign core_rst_n        = r_core_rst_n;
    assign core_flash_data   = r_flash_data;
    assign core_flash_ready  = r_flash_full;
    assign core_sram_data_in = data_reg_a[7:0];
    assign core_in           = in_gpio;
    assign out_gpio          = r_out_gpio;
    assign csr_in_re         = 1'b1;
    assign csr_out_we        = 1'b1;

    // Host register bits that only some builds consume.
    assign w_unused_bits = ^{data_reg_a, data_reg_b, csr_in, w_bp_set};

endmodule

// File: tb/tb_ip_tile_uc_dbg.sv
// Scoreboard bench for ip_tile_uc_dbg with a behavioural core PC that advances on core_ce.
module tb_ip_tile_uc_dbg;

`ifdef IP_TILE_UC_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] csr_in;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [7:0]  in_gpio;
    logic [11:0] core_pc;
    logic [7:0]  core_sram_addr;
    logic [7:0]  core_sram_data_out;
    logic        core_sram_we;
    logic        core_bootstrapping;
    logic        core_flash_ack;
    logic [15:0] core_out;
    logic        core_ce;
    logic        core_rst_n;
    logic [15:0] core_flash_data;
    logic        core_flash_ready;
    logic [7:0]  core_sram_data_in;
    logic [7:0]  core_in;
    logic [15:0] out_gpio;
    logic [31:0] data_reg_c;
    logic [15:0] csr_out;
    logic        csr_in_re;
    logic        csr_out_we;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ce_cnt   = 0;
    int          ce_base;
    logic [11:0] tb_pc;
    logic        pc_load;
    logic [11:0] pc_load_val;

    ip_tile_uc_dbg dut (
        .clk                (clk),
        .arst_n             (arst_n),
        .csr_in             (csr_in),
        .data_reg_a         (data_reg_a),
        .data_reg_b         (data_reg_b),
        .in_gpio            (in_gpio),
        .core_pc            (core_pc),
        .core_sram_addr     (core_sram_addr),
        .core_sram_data_out (core_sram_data_out),
        .core_sram_we       (core_sram_we),
        .core_bootstrapping (core_bootstrapping),
        .core_flash_ack     (core_flash_ack),
        .core_out           (core_out),
        .core_ce            (core_ce),
        .core_rst_n         (core_rst_n),
        .core_flash_data    (core_flash_data),
        .core_flash_ready   (core_flash_ready),
        .core_sram_data_in  (core_sram_data_in),
        .core_in            (core_in),
        .out_gpio           (out_gpio),
        .data_reg_c         (data_reg_c),
        .csr_out            (csr_out),
        .csr_in_re          (csr_in_re),
        .csr_out_we         (csr_out_we)
    );

    always #5 clk = ~clk;

    assign core_pc = tb_pc;

    always @(posedge clk) begin
        if (pc_load) tb_pc <= pc_load_val;
        else if (core_ce) tb_pc <= tb_pc + 12'd1;
    end

    always @(posedge clk) begin
        if (core_ce === 1'b1) ce_cnt <= ce_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.v);
        end
    endtask

    initial begin
        arst_n             = 1'b0;
        csr_in             = 16'h0000;
        data_reg_a         = 32'h0000_009E;
        data_reg_b         = 32'h0;
        in_gpio            = 8'h3C;
        core_sram_addr     = 8'h67;
        core_sram_data_out = 8'h45;
        core_sram_we       = 1'b1;
        core_bootstrapping = 1'b0;
        core_flash_ack     = 1'b0;
        core_out           = 16'h0000;
        pc_load            = 1'b1;
        pc_load_val        = 12'h123;

        // reset state
        exp_push("rst_csr_out", 32'h0080);
        exp_push("rst_core_ce", 32'h0);
        exp_push("rst_core_rst_n", 32'h0);
        exp_push("rst_flash", 32'h0);
        exp_push("rst_gpio", 32'h0);
        exp_push("rst_view0", 32'h0123_4567);
        exp_push("rst_const", 32'h3);
        exp_push("passthru", 32'h9E3C);
        repeat (3) tick();
        exp_pop(32'(csr_out));
        exp_pop(32'(core_ce));
        exp_pop(32'(core_rst_n));
        exp_pop({15'h0, core_flash_ready, core_flash_data});
        exp_pop(32'(out_gpio));
        exp_pop(data_reg_c);
        exp_pop({30'h0, csr_in_re, csr_out_we});
        exp_pop({16'h0, core_sram_data_in, core_in});

        arst_n = 1'b1;
        exp_push("rel_core_rst_n", 32'h1);
        exp_push("rel_state", 32'h0);
        tick();
        exp_pop(32'(core_rst_n));
        exp_pop(32'(csr_out[1:0]));

        // RUN for 10 enabled cycles then HALT
        ce_base = ce_cnt;
        csr_in  = 16'h0001;
        exp_push("run_state", 32'h1);
        tick();
        exp_pop(32'(csr_out[1:0]));
        repeat (9) tick();
        csr_in = 16'h0004;
        exp_push("halt_state", 32'h0);
        exp_push("halt_core_ce", 32'h0);
        exp_push("run_ce_cycles", 32'd10);
        exp_push("run_cyc_cnt", 32'd10);
        tick();
        exp_pop(32'(csr_out[1:0]));
        exp_pop(32'(core_ce));
        exp_pop(32'(ce_cnt - ce_base));
        csr_in = 16'h0084;
        #1;
        exp_pop(data_reg_c);

        // STEP_COUNT=3
        ce_base = ce_cnt;
        csr_in  = 16'h0302;
        exp_push("step3_state", 32'h2);
        tick();
        exp_pop(32'(csr_out[1:0]));
        csr_in = 16'h0300;
        exp_push("step3_ce_cycles", 32'd3);
        exp_push("step3_end_state", 32'h0);
        repeat (5) tick();
        exp_pop(32'(ce_cnt - ce_base));
        exp_pop(32'(csr_out[1:0]));
        csr_in = 16'h0380;
        #1;
        exp_push("step3_cyc_cnt", 32'd13);
        exp_pop(data_reg_c);

        // STEP_COUNT=0 behaves as 1
        ce_base = ce_cnt;
        csr_in  = 16'h0002;
        tick();
        csr_in = 16'h0000;
        exp_push("step0_ce_cycles", 32'd1);
        exp_push("step0_end_state", 32'h0);
        repeat (4) tick();
        exp_pop(32'(ce_cnt - ce_base));
        exp_pop(32'(csr_out[1:0]));

        // STEP held high triggers only once
        ce_base = ce_cnt;
        csr_in  = 16'h0202;
        exp_push("step_held_ce_cycles", 32'd2);
        exp_push("step_held_state", 32'h0);
        repeat (8) tick();
        exp_pop(32'(ce_cnt - ce_base));
        exp_pop(32'(csr_out[1:0]));
        csr_in = 16'h0000;
        tick();

        // breakpoint at PC 5 while running
        pc_load     = 1'b1;
        pc_load_val = 12'h000;
        tick();
        pc_load    = 1'b0;
        data_reg_a = 32'h0005_009E;
        csr_in     = 16'h0021;
        exp_push("bp_state", BP ? 32'h3 : 32'h1);
        exp_push("bp_pc", BP ? 32'h5 : 32'd11);
        exp_push("bp_core_ce", BP ? 32'h0 : 32'h1);
        exp_push("bp_hit", BP ? 32'h1 : 32'h0);
        repeat (12) tick();
        exp_pop(32'(csr_out[1:0]));
        exp_pop(32'(core_pc));
        exp_pop(32'(core_ce));
        exp_pop(32'(csr_out[5]));
        csr_in = 16'h0122;
        tick();
        csr_in = 16'h0120;
        exp_push("bp_step_state", 32'h0);
        exp_push("bp_step_pc", BP ? 32'h6 : 32'd12);
        exp_push("bp_hit_sticky", BP ? 32'h1 : 32'h0);
        repeat (3) tick();
        exp_pop(32'(csr_out[1:0]));
        exp_pop(32'(core_pc));
        exp_pop(32'(csr_out[5]));

        // flash buffer load, overrun, ack gated by core_ce
        csr_in     = 16'h0010;
        data_reg_b = 32'hFFFF_A55A;
        exp_push("fl_load", 32'h1_A55A);
        exp_push("fl_overrun0", 32'h0);
        tick();
        exp_pop({15'h0, core_flash_ready, core_flash_data});
        exp_pop(32'(csr_out[4]));
        csr_in = 16'h0000;
        tick();
        data_reg_b = 32'h0000_BEEF;
        csr_in     = 16'h0010;
        exp_push("fl_overrun_data", 32'h1_A55A);
        exp_push("fl_overrun", 32'h1);
        tick();
        exp_pop({15'h0, core_flash_ready, core_flash_data});
        exp_pop(32'(csr_out[4]));
        csr_in         = 16'h0000;
        core_flash_ack = 1'b1;
        exp_push("fl_ack_no_ce", 32'h1);
        tick();
        exp_pop(32'(core_flash_ready));
        core_flash_ack = 1'b0;
        csr_in         = 16'h0001;
        tick();
        core_flash_ack = 1'b1;
        core_out       = 16'hC3A5;
        exp_push("fl_ack_ready", 32'h0);
        exp_push("gpio_out", 32'hC3A5);
        tick();
        exp_pop(32'(core_flash_ready));
        exp_pop(32'(out_gpio));
        core_flash_ack = 1'b0;

        // CORE_RST in the middle of RUN with sticky flags set
        csr_in = 16'h0009;
        exp_push("crst_core_rst_n", 32'h0);
        exp_push("crst_csr_out", 32'h0080);
        exp_push("crst_cyc_cnt", 32'h0);
        tick();
        exp_pop(32'(core_rst_n));
        exp_pop(32'(csr_out));
        csr_in = 16'h0089;
        #1;
        exp_pop(data_reg_c);
        csr_in = 16'h0001;
        exp_push("crst_rel_core_rst_n", 32'h1);
        exp_push("crst_rel_state", 32'h1);
        tick();
        exp_pop(32'(core_rst_n));
        exp_pop(32'(csr_out[1:0]));

        // new word and ack in the same cycle
        data_reg_b = 32'h0000_1111;
        csr_in     = 16'h0011;
        tick();
        csr_in = 16'h0001;
        tick();
        data_reg_b     = 32'h0000_1234;
        csr_in         = 16'h0011;
        core_flash_ack = 1'b1;
        exp_push("fl_simul", 32'h1_1234);
        exp_push("fl_simul_overrun", 32'h0);
        tick();
        exp_pop({15'h0, core_flash_ready, core_flash_data});
        exp_pop(32'(csr_out[4]));
        core_flash_ack = 1'b0;
        csr_in         = 16'h0004;
        exp_push("final_state", 32'h0);
        tick();
        exp_pop(32'(csr_out[1:0]));

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
